seg_display_ctrl: RTL

- Sequential controller for the three-digit seven-segment readout of the 8-bit temperature value.
- Accepts a value via load/busy handshake, converts it to BCD iteratively (shift-and-add-3, one bit per clock), and latches the digits into display registers.
- Time-multiplexes the three digits onto one shared active-low segment bus with active-low digit enables.
- Sits between the temperature datapath and the board display pins.

---
 rtl/seg_display_pkg.sv | 40 ++++
 rtl/seg_decode.sv | 27 ++
 rtl/seg_display_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display controller.
package seg_display_pkg;

  localparam int unsigned BCD_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 3;
  localparam int unsigned VAL_W  = 8;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables
  localparam logic [AN_W-1:0] AN_ONES  = 3'b110;
  localparam logic [AN_W-1:0] AN_TENS  = 3'b101;
  localparam logic [AN_W-1:0] AN_HUNDS = 3'b011;
  localparam logic [AN_W-1:0] AN_OFF   = 3'b111;

  // Double-dabble correction: a nibble of 5 or more would overflow a decade when doubled
  function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] n);
    return (n >= BCD_W'(5)) ? n + BCD_W'(3) : n;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// BCD digit to active-low seven-segment code; non-decimal nibbles go blank.
module seg_decode
  import seg_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_c_o
);

  // Pure lookup, no state
  always_comb begin
    seg_c_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
      default: seg_c_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Three-digit seven-segment controller: load/busy handshake, iterative
// binary-to-BCD conversion, and a time-multiplexed scan of the committed digits.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] value_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SEG_W-1:0] seg_o,
  output logic [AN_W-1:0]  an_o
);

  localparam int unsigned     CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam int unsigned     CONV_W  = 3 * BCD_W + VAL_W;

  // Conversion datapath
  state_e             state_q;
  logic [VAL_W-1:0]   shift_q;
  logic [BCD_W-1:0]   hund_q, tens_q, ones_q;
  logic [BIT_W-1:0]   bit_q;
  logic               busy_q, done_q;
  logic [CONV_W-1:0]  conv_d;

  // Committed digits shown by the scan
  logic [BCD_W-1:0]   disp_h_q, disp_t_q, disp_o_q;

  // Scan path
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [SEG_W-1:0]   seg_q, seg_d, dig_seg;
  logic [AN_W-1:0]    an_q, an_d;
  logic [BCD_W-1:0]   dig_sel;
  logic               blank_sel;

  // One double-dabble step: correct every nibble, then shift the whole chain left
  always_comb begin
    conv_d = {bcd_adj(hund_q), bcd_adj(tens_q), bcd_adj(ones_q), shift_q} << 1;
  end

  // Handshake and conversion sequencer with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      hund_q   <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      disp_h_q <= '0;
      disp_t_q <= '0;
      disp_o_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_i) begin
            shift_q <= value_i;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {hund_q, tens_q, ones_q, shift_q} <= conv_d;
          bit_q <= bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(VAL_W - 1)) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          disp_h_q <= hund_q;
          disp_t_q <= tens_q;
          disp_o_q <= ones_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Free-running refresh divider; digit index advances on each wrap
  always_comb begin
    rcnt_d = rcnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == CNT_MAX) begin
      rcnt_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Select the digit for the current index and decide leading-zero blanking
  always_comb begin
    dig_sel   = disp_o_q;
    an_d      = AN_ONES;
    blank_sel = 1'b0;
    case (idx_q)
      2'd1: begin
        dig_sel   = disp_t_q;
        an_d      = AN_TENS;
        blank_sel = BLANK_LZ && (disp_h_q == '0) && (disp_t_q == '0);
      end
      2'd2: begin
        dig_sel   = disp_h_q;
        an_d      = AN_HUNDS;
        blank_sel = BLANK_LZ && (disp_h_q == '0);
      end
      default: begin
        dig_sel   = disp_o_q;
        an_d      = AN_ONES;
        blank_sel = 1'b0;
      end
    endcase
  end

  seg_decode u_seg_decode (
    .bcd_i   (dig_sel),
    .seg_c_o (dig_seg)
  );

  assign seg_d = blank_sel ? SEG_BLANK : dig_seg;

  // Scan registers; pins follow index/digit changes by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= AN_OFF;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign seg_o  = seg_q;
  assign an_o   = an_q;

endmodule
